// File: rtl/cmd_bridge.sv
// Byte-stream command bridge: parses header/length frames into word writes and reads.
// Optional inter-byte timeout enabled by defining CMD_BRIDGE_TIMEOUT_EN.
module cmd_bridge #(
    parameter int DATA_BYTES  = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rxData,
    input  logic                    rxValid,
    output logic [7:0]              txData,
    output logic                    txSend,
    input  logic                    txBusy,
    output logic                    we,
    output logic                    re,
    output logic [6:0]              addr,
    input  logic [8*DATA_BYTES-1:0] rdat,
    output logic [8*DATA_BYTES-1:0] wdat,
    output logic                    rxack,
    output logic                    err
);

    localparam int W = 8 * DATA_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_WDATA,
        S_WRITE,
        S_RREQ,
        S_RCAP,
        S_TX
    } state_t;

    state_t         state_q, state_d;
    logic           rw_q, rw_d;
    logic [6:0]     addr_q, addr_d;
    logic [7:0]     words_q, words_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [W-1:0]   wsh_q, wsh_d;
    logic [W-1:0]   wdat_q, wdat_d;
    logic [W-1:0]   rsh_q, rsh_d;
    logic [7:0]     txData_q, txData_d;
    logic           txSend_q, txSend_d;
    logic           rxack_q, rxack_d;
    logic           err_q, err_d;

    logic accept;
    logic last_byte;
    logic last_word;
    logic tx_go;
    logic waiting;
    logic timeout;

    assign accept    = rxValid && (state_q == S_IDLE || state_q == S_LEN
                                   || state_q == S_WDATA);
    assign last_byte = (cnt_q == 3'(DATA_BYTES - 1));
    assign last_word = (words_q == 8'd0);
    assign tx_go     = (state_q == S_TX) && !txBusy && !txSend_q;
    assign waiting   = (state_q == S_LEN) || (state_q == S_WDATA);

`ifdef CMD_BRIDGE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TW-1:0] to_q, to_d;

    assign timeout = waiting && !rxValid && (to_q == TW'(TIMEOUT_CYC - 1));

    // Idle-cycle counter, cleared by any accepted byte or when not waiting
    always_comb begin
        to_d = to_q + TW'(1);
        if (accept || !waiting || timeout) begin
            to_d = '0;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_LEN;
            end
            S_LEN: begin
                if (timeout)     state_d = S_IDLE;
                else if (accept) state_d = rw_q ? S_RREQ : S_WDATA;
            end
            S_WDATA: begin
                if (timeout)                  state_d = S_IDLE;
                else if (accept && last_byte) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_word ? S_IDLE : S_WDATA;
            end
            S_RREQ: begin
                state_d = S_RCAP;
            end
            S_RCAP: begin
                state_d = S_TX;
            end
            S_TX: begin
                if (tx_go && last_byte) begin
                    state_d = last_word ? S_IDLE : S_RREQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory strobes decoded straight from the state
    always_comb begin
        we = (state_q == S_WRITE);
        re = (state_q == S_RREQ);
    end

    // Datapath next-state: address, counters, shift registers, pulses
    always_comb begin
        rw_d     = rw_q;
        addr_d   = addr_q;
        words_d  = words_q;
        cnt_d    = cnt_q;
        wsh_d    = wsh_q;
        wdat_d   = wdat_q;
        rsh_d    = rsh_q;
        txData_d = txData_q;
        txSend_d = 1'b0;
        rxack_d  = accept;
        err_d    = timeout;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rw_d   = rxData[7];
                    addr_d = rxData[6:0];
                    cnt_d  = 3'd0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    words_d = rxData;
                    cnt_d   = 3'd0;
                end
            end
            S_WDATA: begin
                if (timeout) begin
                    cnt_d = 3'd0;
                end else if (accept) begin
                    wsh_d = (wsh_q << 8) | W'(rxData);
                    if (last_byte) begin
                        wdat_d = wsh_d;
                        cnt_d  = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + 7'd1;
                if (!last_word) words_d = words_q - 8'd1;
            end
            S_RREQ: begin
                cnt_d = 3'd0;
            end
            S_RCAP: begin
                rsh_d = rdat;
                cnt_d = 3'd0;
            end
            S_TX: begin
                if (tx_go) begin
                    txSend_d = 1'b1;
                    txData_d = rsh_q[W-1 -: 8];
                    rsh_d    = rsh_q << 8;
                    if (last_byte) begin
                        cnt_d  = 3'd0;
                        addr_d = addr_q + 7'd1;
                        if (!last_word) words_d = words_q - 8'd1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rw_q     <= 1'b0;
            addr_q   <= '0;
            words_q  <= '0;
            cnt_q    <= '0;
            wsh_q    <= '0;
            wdat_q   <= '0;
            rsh_q    <= '0;
            txData_q <= '0;
            txSend_q <= 1'b0;
            rxack_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            words_q  <= words_d;
            cnt_q    <= cnt_d;
            wsh_q    <= wsh_d;
            wdat_q   <= wdat_d;
            rsh_q    <= rsh_d;
            txData_q <= txData_d;
            txSend_q <= txSend_d;
            rxack_q  <= rxack_d;
            err_q    <= err_d;
        end
    end

    assign addr   = addr_q;
    assign wdat   = wdat_q;
    assign txData = txData_q;
    assign txSend = txSend_q;
    assign rxack  = rxack_q;
    assign err    = err_q;

endmodule

// File: tb/tb_cmd_bridge.sv
// Scoreboard bench for cmd_bridge: frame-level reference model, decoupled monitor.
// Timeout scenario runs when CMD_BRIDGE_TIMEOUT_EN is defined.
module tb_cmd_bridge;

    localparam int DB = 4;
    localparam int W  = 8 * DB;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rxData;
    logic         rxValid;
    logic [7:0]   txData;
    logic         txSend;
    logic         txBusy;
    logic         we;
    logic         re;
    logic [6:0]   addr;
    logic [W-1:0] rdat;
    logic [W-1:0] wdat;
    logic         rxack;
    logic         err;

    cmd_bridge #(.DATA_BYTES(DB), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .rst(rst), .rxData(rxData), .rxValid(rxValid),
        .txData(txData), .txSend(txSend), .txBusy(txBusy),
        .we(we), .re(re), .addr(addr), .rdat(rdat), .wdat(wdat),
        .rxack(rxack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   a;
        logic [W-1:0] d;
    } wr_t;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] bmem [128];
    logic [W-1:0] mmem [128];
    wr_t          exp_we [$];
    logic [6:0]   exp_re [$];
    logic [7:0]   exp_tx [$];
    logic [7:0]   dq [$];

    int busy_len = 10;
    int busy_cnt = 0;
    int ack_seen = 0;
    int ack_exp  = 0;
    int err_seen = 0;
    int err_exp  = 0;
    logic prev_send = 1'b0;
    wr_t  me;
    logic [6:0] mre;
    logic [7:0] mtx;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Environment: transmitter busy model and memory behind rdat
    assign txBusy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (txSend) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (re) rdat <= bmem[addr];
        if (we) bmem[addr] <= wdat;
    end

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (we) begin
            check("we_re_excl", 64'(re), 64'(0));
            if (exp_we.size() == 0) begin
                tests++; fails++;
                $display("FAIL we_unexpected: got addr %0h expected none", addr);
            end else begin
                me = exp_we.pop_front();
                check("we_addr", 64'(addr), 64'(me.a));
                check("we_data", 64'(wdat), 64'(me.d));
            end
        end
        if (re) begin
            if (exp_re.size() == 0) begin
                tests++; fails++;
                $display("FAIL re_unexpected: got addr %0h expected none", addr);
            end else begin
                mre = exp_re.pop_front();
                check("re_addr", 64'(addr), 64'(mre));
            end
        end
        if (txSend) begin
            check("tx_while_busy", 64'(txBusy), 64'(0));
            check("tx_back_to_back", 64'(prev_send), 64'(0));
            if (exp_tx.size() == 0) begin
                tests++; fails++;
                $display("FAIL tx_unexpected: got %0h expected none", txData);
            end else begin
                mtx = exp_tx.pop_front();
                check("tx_byte", 64'(txData), 64'(mtx));
            end
        end
        if (rxack) ack_seen++;
        if (err) err_seen++;
        prev_send = txSend;
    end

    task automatic send_byte(input logic [7:0] b, input bit acc);
        @(negedge clk);
        rxData  = b;
        rxValid = 1'b1;
        @(negedge clk);
        rxValid = 1'b0;
        check("rxack", 64'(rxack), 64'(acc));
        if (acc) ack_exp++;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_tx.size() + exp_we.size() + exp_re.size()) > 0
               && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check("drain", 64'(exp_tx.size() + exp_we.size() + exp_re.size()),
              64'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic push_writes(input logic [6:0] a, input int n);
        wr_t e;
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int j = 0; j < DB; j++) w = {w[W-9:0], dq[i*DB+j]};
            e.a = a + 7'(i);
            e.d = w;
            exp_we.push_back(e);
            mmem[e.a] = w;
        end
    endtask

    task automatic write_frame(input logic [6:0] a, input int n);
        push_writes(a, n);
        send_byte({1'b0, a}, 1'b1);
        send_byte(8'(n - 1), 1'b1);
        foreach (dq[k]) send_byte(dq[k], 1'b1);
        wait_idle();
    endtask

    task automatic push_reads(input logic [6:0] a, input int n);
        logic [6:0] aa;
        logic [W-1:0] w;
        for (int i = 0; i < n; i++) begin
            aa = a + 7'(i);
            exp_re.push_back(aa);
            w = mmem[aa];
            for (int j = 0; j < DB; j++) exp_tx.push_back(w[W-1-8*j -: 8]);
        end
    endtask

    task automatic wait_sends(input int nth);
        int c = 0;
        int k = 0;
        while (c < nth && k < 5000) begin
            @(negedge clk);
            if (txSend) c++;
            k++;
        end
        check("txsend_seen", 64'(c), 64'(nth));
    endtask

    task automatic read_frame(input logic [6:0] a, input int n,
                              input bit inject);
        push_reads(a, n);
        send_byte({1'b1, a}, 1'b1);
        send_byte(8'(n - 1), 1'b1);
        if (inject) begin
            wait_sends(1);
            repeat (2) @(negedge clk);
            send_byte(8'h55, 1'b0);
        end
        wait_idle();
    endtask

    task automatic fill_dq(input int nbytes);
        dq.delete();
        for (int i = 0; i < nbytes; i++) dq.push_back(8'($urandom));
    endtask

    int e0;
    int sc;

    initial begin
        for (int i = 0; i < 128; i++) begin
            bmem[i] = W'(i) * 32'h01010101;
            mmem[i] = W'(i) * 32'h01010101;
        end
        rdat    = '0;
        rst     = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", 64'(we), 64'(0));
        check("rst_re", 64'(re), 64'(0));
        check("rst_txsend", 64'(txSend), 64'(0));
        check("rst_txdata", 64'(txData), 64'(0));
        check("rst_addr", 64'(addr), 64'(0));
        check("rst_wdat", 64'(wdat), 64'(0));
        check("rst_rxack", 64'(rxack), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Read burst 0x03..0x05 with a 10-cycle transmitter
        busy_len = 10;
        read_frame(7'h03, 3, 1'b0);

        // Single word write
        dq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        write_frame(7'h05, 1);

        // Two words wrapping 0x7F -> 0x00
        dq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        write_frame(7'h7F, 2);

        // Dropped byte during TX
        read_frame(7'h7F, 2, 1'b1);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            int n;
            logic [6:0] a;
            n        = int'($urandom_range(1, 4));
            a        = 7'($urandom);
            busy_len = int'($urandom_range(1, 12));
            if ($urandom_range(0, 1) == 0) begin
                fill_dq(n * DB);
                write_frame(a, n);
            end else begin
                read_frame(a, n, 1'b0);
            end
        end

        // Reset during the second TX byte
        busy_len = 10;
        push_reads(7'h20, 2);
        send_byte(8'hA0, 1'b1);
        send_byte(8'h01, 1'b1);
        wait_sends(2);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_we", 64'(we), 64'(0));
        check("mid_rst_re", 64'(re), 64'(0));
        check("mid_rst_txsend", 64'(txSend), 64'(0));
        check("mid_rst_txdata", 64'(txData), 64'(0));
        check("mid_rst_addr", 64'(addr), 64'(0));
        check("mid_rst_wdat", 64'(wdat), 64'(0));
        check("mid_rst_rxack", 64'(rxack), 64'(0));
        check("mid_rst_err", 64'(err), 64'(0));
        exp_tx.delete();
        exp_re.delete();
        rst = 1'b0;
        sc = 0;
        repeat (60) begin
            @(negedge clk);
            if (txSend || re || we) sc++;
        end
        check("quiet_after_rst", 64'(sc), 64'(0));
        dq = '{8'h01, 8'h02, 8'h03, 8'h04};
        write_frame(7'h30, 1);

        // Stalled partial frame
        e0 = err_seen;
        send_byte(8'h10, 1'b1);
        send_byte(8'h00, 1'b1);
`ifdef CMD_BRIDGE_TIMEOUT_EN
        send_byte(8'hAA, 1'b1);
        repeat (95) @(negedge clk);
        check("err_early", 64'(err_seen - e0), 64'(0));
        repeat (30) @(negedge clk);
        check("err_pulse", 64'(err_seen - e0), 64'(1));
        err_exp++;
        dq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        write_frame(7'h11, 1);
`else
        dq = '{8'hAA, 8'hB1, 8'hB2, 8'hB3};
        push_writes(7'h10, 1);
        send_byte(8'hAA, 1'b1);
        repeat (150) @(negedge clk);
        check("no_err", 64'(err_seen - e0), 64'(0));
        send_byte(8'hB1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hB3, 1'b1);
        wait_idle();
`endif

        check("rxack_count", 64'(ack_seen), 64'(ack_exp));
        check("err_count", 64'(err_seen), 64'(err_exp));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
